// File: rtl/uart_tx_fifo_if.sv
// Byte-stream interface between the MMIO store path, the TX FIFO and uart_tx.
// The FIFO is the slave side; the core/transmitter environment is the master.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 16
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          flush;
  logic          clr_overflow;
  logic [7:0]    tx_data;
  logic          tx_data_valid;
  logic          tx_data_ready;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic          overflow;

  modport master (
    output wr_en, wr_data, flush, clr_overflow, tx_data_ready,
    input  tx_data, tx_data_valid, count, empty, full, almost_full, overflow
  );

  modport slave (
    input  wr_en, wr_data, flush, clr_overflow, tx_data_ready,
    output tx_data, tx_data_valid, count, empty, full, almost_full, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Show-ahead byte FIFO feeding uart_tx: registered head byte and valid,
// occupancy status decoded from a registered count, and a sticky overflow flag.
module uart_tx_fifo #(
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_fifo_if.slave  bus
);
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int DATA_W = 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_nxt;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_nxt;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] head_nxt;
  logic              tx_vld;
  logic              overflow;
  logic              full;
  logic              push;
  logic              pop;
  logic              drop;

  assign full = (count == CW'(DEPTH));
  assign push = bus.wr_en && !full && !bus.flush;
  assign drop = bus.wr_en && full && !bus.flush;
  assign pop  = tx_vld && bus.tx_data_ready && !bus.flush;

  assign count_nxt = count + CW'(push) - CW'(pop);
  assign rd_nxt    = rd_ptr + AW'(pop);

  // A byte written into the slot that becomes the head this edge is not yet in mem.
  assign head_nxt = (push && (wr_ptr == rd_nxt)) ? bus.wr_data : mem[rd_nxt];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      tx_vld   <= 1'b0;
      tx_data  <= '0;
      overflow <= 1'b0;
    end else begin
      if (bus.flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        tx_vld <= 1'b0;
      end else begin
        rd_ptr  <= rd_nxt;
        wr_ptr  <= wr_ptr + AW'(push);
        count   <= count_nxt;
        // A byte landing in an empty FIFO is presented one cycle later.
        tx_vld  <= (count != '0) && (count_nxt != '0);
        tx_data <= head_nxt;
      end
      if (drop)                  overflow <= 1'b1;
      else if (bus.clr_overflow) overflow <= 1'b0;
    end
  end

  assign bus.tx_data       = tx_data;
  assign bus.tx_data_valid = tx_vld;
  assign bus.count         = count;
  assign bus.empty         = (count == '0);
  assign bus.full          = full;
  assign bus.almost_full   = (count >= CW'(AFULL_LVL));
  assign bus.overflow      = overflow;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo with a queue-based reference model and a
// negedge monitor that scores every handshake and status output.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   n_popped = 0;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] q[$];
  bit         ov_m = 1'b0;
  bit         fresh = 1'b0;
  bit         valid_m;
  bit         was_empty;
  bit         do_push;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: scores the current outputs, then applies this cycle's inputs.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      ov_m  = 1'b0;
      fresh = 1'b0;
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_valid", 32'(bus.tx_data_valid), 0);
      chk("rst_tx_data", 32'(bus.tx_data), 0);
      chk("rst_empty", 32'(bus.empty), 1);
      chk("rst_full", 32'(bus.full), 0);
      chk("rst_overflow", 32'(bus.overflow), 0);
    end else begin
      valid_m = (q.size() != 0) && !fresh;
      chk("count", 32'(bus.count), 32'(q.size()));
      chk("empty", 32'(bus.empty), 32'(q.size() == 0));
      chk("full", 32'(bus.full), 32'(q.size() == DEPTH));
      chk("almost_full", 32'(bus.almost_full), 32'(q.size() >= AFULL));
      chk("overflow", 32'(bus.overflow), 32'(ov_m));
      chk("tx_valid", 32'(bus.tx_data_valid), 32'(valid_m));
      if (valid_m && q.size() != 0) chk("tx_data", 32'(bus.tx_data), 32'(q[0]));
      if (bus.flush) begin
        q.delete();
        fresh = 1'b0;
        if (bus.clr_overflow) ov_m = 1'b0;
      end else begin
        was_empty = (q.size() == 0);
        do_push   = bus.wr_en && (q.size() < DEPTH);
        if (valid_m && bus.tx_data_ready) begin
          void'(q.pop_front());
          n_popped++;
        end
        if (do_push) q.push_back(bus.wr_data);
        fresh = was_empty && do_push;
        if (bus.wr_en && !do_push) ov_m = 1'b1;
        else if (bus.clr_overflow) ov_m = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic drain();
    bus.wr_en = 1'b0;
    bus.tx_data_ready = 1'b1;
    for (int i = 0; i < 200 && !bus.empty; i++) step();
    chk("drain_done", 32'(bus.empty), 1);
    step();
    bus.tx_data_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.clr_overflow = 1'b1;
    step();
    bus.clr_overflow = 1'b0;
  endtask

  int base;

  initial begin
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    bus.flush = 1'b0;
    bus.clr_overflow = 1'b0;
    bus.tx_data_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Three bytes held, then released in order
    wr(8'h41); wr(8'h42); wr(8'h43);
    step();
    chk("t1_count", 32'(bus.count), 3);
    chk("t1_head", 32'(bus.tx_data), 32'h41);
    chk("t1_valid", 32'(bus.tx_data_valid), 1);
    step(); step();
    chk("t1_stable", 32'(bus.tx_data), 32'h41);
    base = n_popped;
    drain();
    chk("t1_pops", 32'(n_popped - base), 3);

    // Fill to full, drop one, drain, clear overflow
    for (int i = 0; i < DEPTH; i++) begin
      wr(8'(i));
      chk("t2_afull", 32'(bus.almost_full), 32'((i + 1) >= AFULL));
    end
    chk("t2_full", 32'(bus.full), 1);
    wr(8'hFF);
    chk("t2_overflow", 32'(bus.overflow), 1);
    chk("t2_count", 32'(bus.count), DEPTH);
    base = n_popped;
    drain();
    chk("t2_pops", 32'(n_popped - base), DEPTH);
    pulse_clr();
    chk("t2_clr", 32'(bus.overflow), 0);

    // Steady push+pop at count 8 across several pointer wraps
    for (int i = 0; i < 8; i++) wr(8'($urandom));
    step();
    bus.wr_en = 1'b1;
    bus.tx_data_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.wr_data = 8'($urandom);
      step();
      chk("t3_count", 32'(bus.count), 8);
    end
    bus.wr_en = 1'b0;
    bus.tx_data_ready = 1'b0;
    drain();

    // Full with simultaneous write and pop
    for (int i = 0; i < DEPTH; i++) wr(8'(8'h80 + i));
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hAA;
    bus.tx_data_ready = 1'b1;
    step();
    bus.wr_en = 1'b0;
    bus.tx_data_ready = 1'b0;
    chk("t4_count", 32'(bus.count), DEPTH - 1);
    chk("t4_overflow", 32'(bus.overflow), 1);
    pulse_clr();
    drain();

    // Flush beats a same-cycle write
    for (int i = 0; i < 5; i++) wr(8'(8'h10 + i));
    bus.flush = 1'b1;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h77;
    step();
    bus.flush = 1'b0;
    bus.wr_en = 1'b0;
    chk("t5_count", 32'(bus.count), 0);
    chk("t5_valid", 32'(bus.tx_data_valid), 0);
    chk("t5_overflow", 32'(bus.overflow), 0);
    wr(8'h55);
    step();
    chk("t5_valid2", 32'(bus.tx_data_valid), 1);
    chk("t5_data", 32'(bus.tx_data), 32'h55);
    drain();

    // Asynchronous reset in the middle of a transfer
    for (int i = 0; i < 6; i++) wr(8'(8'hC0 + i));
    step();
    bus.tx_data_ready = 1'b1;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_count", 32'(bus.count), 0);
    chk("t6_valid", 32'(bus.tx_data_valid), 0);
    chk("t6_data", 32'(bus.tx_data), 0);
    chk("t6_empty", 32'(bus.empty), 1);
    step();
    rst_n = 1'b1;
    step(); step();
    chk("t6_no_valid", 32'(bus.tx_data_valid), 0);
    bus.tx_data_ready = 1'b0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bus.wr_en         = ($urandom_range(0, 3) != 0);
      bus.wr_data       = 8'($urandom);
      bus.tx_data_ready = ($urandom_range(0, 1) != 0);
      bus.flush         = ($urandom_range(0, 39) == 0);
      bus.clr_overflow  = ($urandom_range(0, 15) == 0);
      step();
    end
    bus.flush = 1'b0;
    bus.clr_overflow = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
